// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, saturating overflow counter
// and an optional overflow trap (compile with OVF_TRAP_EN to enable the RUN/TRAP FSM).
module ex_mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_zout,
  input  logic              alu_overflow,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              branch_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              zero_out,
  output logic [4:0]        wreg_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              branch_out,
  output logic              exc_pending,
  output logic [DATA_W-1:0] epc,
  input  logic              exc_ack,
  output logic [7:0]        ovf_count
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              w_accept;
  logic              w_take;
  logic              w_ovf_evt;
  logic              w_trap_evt;
  logic              w_in_trap;
  logic [3:0]        w_ctl_in;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic              r_zero_p1;
  logic [4:0]        r_wreg_p1;
  logic [3:0]        r_ctl_p1;
  logic [7:0]        r_ovf_count;

  assign in_ready  = (~r_vld_p1 | out_ready) & ~w_in_trap;
  assign w_accept  = in_valid & in_ready;
  // A beat discarded by flush never counts as an overflow event.
  assign w_take    = w_accept & ~flush;
  assign w_ovf_evt = w_take & alu_overflow;
  assign w_ctl_in  = {reg_write_in, mem_read_in, mem_write_in, branch_in};

`ifdef OVF_TRAP_EN
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_epc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_ovf_evt) w_state_nxt = TRAP;
      TRAP:    if (exc_ack)   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)           r_epc <= '0;
    else if (w_trap_evt) r_epc <= pc_in;
  end

  assign w_in_trap   = (r_state == TRAP);
  assign w_trap_evt  = w_ovf_evt & (r_state == RUN);
  assign exc_pending = w_in_trap;
  assign epc         = r_epc;
`else
  logic w_unused;
  assign w_unused    = ^{pc_in, exc_ack};
  assign w_in_trap   = 1'b0;
  assign w_trap_evt  = 1'b0;
  assign exc_pending = 1'b0;
  assign epc         = '0;
`endif

  // Stage p1: registered beat; a trapping beat still flows but with its side effects killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_wdata_p1 <= '0;
      r_zero_p1  <= 1'b0;
      r_wreg_p1  <= '0;
      r_ctl_p1   <= '0;
    end else if (flush) begin
      r_vld_p1   <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1   <= 1'b1;
      r_addr_p1  <= alu_sum;
      r_wdata_p1 <= rt_data;
      r_zero_p1  <= alu_zout;
      r_wreg_p1  <= write_reg;
      r_ctl_p1   <= w_trap_evt ? 4'b0000 : w_ctl_in;
    end else if (r_vld_p1 & out_ready) begin
      r_vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          r_ovf_count <= '0;
    else if (w_ovf_evt) r_ovf_count <= sat_inc8(r_ovf_count);
  end

  assign out_valid     = r_vld_p1;
  assign mem_addr      = r_addr_p1;
  assign mem_wdata     = r_wdata_p1;
  assign zero_out      = r_zero_p1;
  assign wreg_out      = r_wreg_p1;
  assign reg_write_out = r_ctl_p1[3];
  assign mem_read_out  = r_ctl_p1[2];
  assign mem_write_out = r_ctl_p1[1];
  assign branch_out    = r_ctl_p1[0];
  assign ovf_count     = r_ovf_count;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed beats push expectations, a monitor pops on retire.
module tb_ex_mem_stage;

`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_sum = '0;
  logic        alu_zout = 1'b0;
  logic        alu_overflow = 1'b0;
  logic [31:0] rt_data = '0;
  logic [4:0]  write_reg = '0;
  logic [31:0] pc_in = '0;
  logic        reg_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        branch_in = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        zero_out;
  logic [4:0]  wreg_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        branch_out;
  logic        exc_pending;
  logic [31:0] epc;
  logic        exc_ack = 1'b0;
  logic [7:0]  ovf_count;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_overflow(alu_overflow),
    .rt_data(rt_data), .write_reg(write_reg), .pc_in(pc_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .branch_in(branch_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .zero_out(zero_out), .wreg_out(wreg_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .branch_out(branch_out),
    .exc_pending(exc_pending), .epc(epc), .exc_ack(exc_ack),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        z;
    logic [4:0]  wreg;
    logic [3:0]  ctl;
  } beat_t;

  beat_t exp_q[$];
  int    errs = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] sum, input logic [31:0] wd, input logic z,
                          input logic ovf, input logic [4:0] wr, input logic [31:0] pc,
                          input logic [3:0] ctl);
    alu_sum = sum; rt_data = wd; alu_zout = z; alu_overflow = ovf;
    write_reg = wr; pc_in = pc;
    {reg_write_in, mem_read_in, mem_write_in, branch_in} = ctl;
  endtask

  // Offer one beat, push its expected output when the handshake is seen, return after the accept edge.
  task automatic offer(input logic [31:0] sum, input logic [31:0] wd, input logic z,
                       input logic ovf, input logic [4:0] wr, input logic [31:0] pc,
                       input logic [3:0] ctl);
    bit done = 1'b0;
    set_beat(sum, wd, z, ovf, wr, pc, ctl);
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{sum, wd, z, wr, (TRAP && ovf) ? 4'b0000 : ctl});
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL offer_timeout: in_ready stayed 0, expected 1 within 20 cycles");
    end
  endtask

  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_beat: got mem_addr 0x%08h, expected no beat", mem_addr);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("sb_mem_addr", mem_addr, e.addr);
        chk("sb_mem_wdata", mem_wdata, e.wdata);
        chk("sb_zero_out", {31'd0, zero_out}, {31'd0, e.z});
        chk("sb_wreg_out", {27'd0, wreg_out}, {27'd0, e.wreg});
        chk("sb_ctl", {28'd0, reg_write_out, mem_read_out, mem_write_out, branch_out},
            {28'd0, e.ctl});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t drop;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_exc_pending", {31'd0, exc_pending}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_ovf_count", {24'd0, ovf_count}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Case 1: single beat, 1-cycle latency
    step();
    out_ready = 1'b1;
    offer(32'h0000_0010, 32'hCAFE_0001, 1'b0, 1'b0, 5'd5, 32'h0000_0100, 4'b1000);
    @(negedge clk);
    chk("c1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c1_mem_addr", mem_addr, 32'h10);
    chk("c1_wreg_out", {27'd0, wreg_out}, 32'd5);
    chk("c1_reg_write_out", {31'd0, reg_write_out}, 32'd1);

    // Case 2: back-pressure holds beat A, then A retires and B enters on the same edge
    step();
    out_ready = 1'b0;
    offer(32'h0000_0A00, 32'h1111_2222, 1'b0, 1'b0, 5'd7, 32'h0000_0104, 4'b0100);
    set_beat(32'h0000_0000, 32'h3333_4444, 1'b1, 1'b0, 5'd9, 32'h0000_0108, 4'b0011);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("c2_in_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("c2_mem_addr_hold", mem_addr, 32'h0000_0A00);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("c2_in_ready_release", {31'd0, in_ready}, 32'd1);
    exp_q.push_back('{32'h0000_0000, 32'h3333_4444, 1'b1, 5'd9, 4'b0011});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("c2_out_valid_b", {31'd0, out_valid}, 32'd1);
    chk("c2_wdata_b", mem_wdata, 32'h3333_4444);

    // Case 3: overflow beat
    step();
    offer(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 5'd3, 32'h0040_0020, 4'b1000);
    @(negedge clk);
    chk("c3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c3_reg_write_out", {31'd0, reg_write_out}, TRAP ? 32'd0 : 32'd1);
    chk("c3_epc", epc, TRAP ? 32'h0040_0020 : 32'd0);
    chk("c3_exc_pending", {31'd0, exc_pending}, {31'd0, TRAP});
    chk("c3_in_ready", {31'd0, in_ready}, TRAP ? 32'd0 : 32'd1);
    chk("c3_ovf_count", {24'd0, ovf_count}, 32'd1);
    step();
    exc_ack = 1'b1;
    @(negedge clk);
    chk("c3_in_ready_trap", {31'd0, in_ready}, TRAP ? 32'd0 : 32'd1);
    step();
    exc_ack = 1'b0;
    @(negedge clk);
    chk("c3_in_ready_ack", {31'd0, in_ready}, 32'd1);
    chk("c3_exc_pending_ack", {31'd0, exc_pending}, 32'd0);

    // Case 4: flush while holding, with an overflow beat offered
    step();
    out_ready = 1'b0;
    offer(32'h0000_0C00, 32'h5555_6666, 1'b0, 1'b0, 5'd12, 32'h0000_0200, 4'b0010);
    set_beat(32'h8000_0000, 32'h0, 1'b0, 1'b1, 5'd13, 32'h0000_0204, 4'b1000);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("c4_in_ready_hold", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("c4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("c4_ovf_count", {24'd0, ovf_count}, 32'd1);
    chk("c4_exc_pending", {31'd0, exc_pending}, 32'd0);
    drop = exp_q.pop_back();

    // Flush with an acceptable overflow beat: discarded, no count, no trap
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("c4b_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("c4b_out_valid", {31'd0, out_valid}, 32'd0);
    chk("c4b_ovf_count", {24'd0, ovf_count}, 32'd1);
    chk("c4b_exc_pending", {31'd0, exc_pending}, 32'd0);
    chk("c4b_epc", epc, TRAP ? 32'h0040_0020 : 32'd0);

    // Case 5: 256 acknowledged overflow beats saturate the counter
    step();
    for (int i = 0; i < 256; i++) begin
      offer(32'h0001_0000 + i, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0000_1000 + 4 * i, 4'b1100);
      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
    end
    @(negedge clk);
    chk("c5_ovf_count", {24'd0, ovf_count}, 32'd255);
    chk("c5_exc_pending", {31'd0, exc_pending}, 32'd0);
    chk("c5_epc", epc, TRAP ? 32'h0000_13FC : 32'd0);

    // Case 6: reset while a trapping beat is held
    step();
    out_ready = 1'b0;
    offer(32'hFFFF_0000, 32'h9999_8888, 1'b0, 1'b1, 5'd31, 32'h0040_0040, 4'b1111);
    @(negedge clk);
    chk("c6_pre_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c6_pre_exc_pending", {31'd0, exc_pending}, {31'd0, TRAP});
    chk("c6_pre_ovf_count", {24'd0, ovf_count}, 32'd255);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("c6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("c6_mem_addr", mem_addr, 32'd0);
    chk("c6_mem_wdata", mem_wdata, 32'd0);
    chk("c6_wreg_out", {27'd0, wreg_out}, 32'd0);
    chk("c6_ctl", {28'd0, reg_write_out, mem_read_out, mem_write_out, branch_out}, 32'd0);
    chk("c6_exc_pending", {31'd0, exc_pending}, 32'd0);
    chk("c6_epc", epc, 32'd0);
    chk("c6_ovf_count", {24'd0, ovf_count}, 32'd0);
    chk("c6_in_ready", {31'd0, in_ready}, 32'd1);
    drop = exp_q.pop_back();

    // Normal traffic after reset
    step();
    out_ready = 1'b1;
    offer(32'h0000_0044, 32'h0BAD_F00D, 1'b0, 1'b0, 5'd2, 32'h0000_0300, 4'b0001);
    repeat (3) step();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
